// File: rtl/cpu_control_pkg.sv
// Shared types for the 8-bit core control path: ALU opcodes and flags,
// CPU instruction opcodes, sequencer states and the instruction layout.
package cpu_control_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_opcode_t;

  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
    logic carry;
  } alu_flags_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_JMP  = 4'hA,
    OP_BZ   = 4'hB,
    OP_BC   = 4'hC,
    OP_BN   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } cpu_opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } ctrl_state_t;

  typedef struct packed {
    cpu_opcode_t op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
  } instr_t;

  // Opcodes 0x0-0x8 go through the ALU and update the flag register.
  function automatic logic is_alu_op(cpu_opcode_t op);
    return (op <= OP_ADDI);
  endfunction

  // Reg-reg opcodes map 1:1 onto the ALU encoding; everything else adds.
  function automatic alu_opcode_t alu_op_of(cpu_opcode_t op);
    logic [3:0] code;
    code = op;
    if (code[3]) return ALU_ADD;
    return alu_opcode_t'(code[2:0]);
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Instruction-fetch port: the control unit issues req/addr and holds them
// until the memory answers with ack and the instruction word.
interface cpu_control_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/cpu_control_cond_eval.sv
// Branch condition resolution from the architectural flags; kept
// combinational and standalone so a pipelined core can reuse it.
module cond_eval
  import cpu_control_pkg::*;
(
  input  cpu_opcode_t op,
  input  alu_flags_t  flags_q,
  output logic        take_branch
);

  // Select the flag tested by the branch opcode; JMP is always taken.
  always_comb begin
    take_branch = 1'b0;
    case (op)
      OP_JMP:  take_branch = 1'b1;
      OP_BZ:   take_branch = flags_q.zero;
      OP_BC:   take_branch = flags_q.carry;
      OP_BN:   take_branch = flags_q.negative;
      default: take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle sequencer for the 8-bit core: fetches over a req/ack port,
// decodes into ALU and register-file controls, owns the flag register and
// resolves branches. FETCH -> DECODE -> EXEC takes three cycles per
// instruction plus one per ack-wait cycle.
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  cpu_control_if.master      imem,
  output alu_opcode_t        alu_op,
  output logic               alu_src_imm,
  input  alu_flags_t         alu_flags,
  output logic [1:0]         rd_sel,
  output logic [1:0]         rs_sel,
  output logic [WIDTH-1:0]   imm,
  output logic               wb_sel_imm,
  output logic               reg_we,
  output alu_flags_t         flags_q,
  output logic               halted
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] pc;
  instr_t            instr;
  logic              take_branch;
  logic              in_decode_exec;

  cond_eval u_cond_eval (
    .op          (instr.op),
    .flags_q     (flags_q),
    .take_branch (take_branch)
  );

  // Sequencer: state, pc, latched instruction, decoded fields and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      instr   <= '0;
      flags_q <= '0;
      alu_op  <= ALU_ADD;
      rd_sel  <= '0;
      rs_sel  <= '0;
      imm     <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem.imem_ack) begin
            instr <= instr_t'(imem.imem_rdata);
            pc    <= pc + ADDR_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_op <= alu_op_of(instr.op);
          rd_sel <= instr.rd;
          rs_sel <= instr.rs;
          imm    <= WIDTH'(instr.imm);
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          // Branches see flags_q from before this cycle; only ALU ops write it.
          if (is_alu_op(instr.op)) flags_q <= alu_flags;
          if (take_branch) pc <= ADDR_W'(instr.imm);
          state <= (instr.op == OP_HALT) ? ST_HALT : ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes and selects decode only from registered state, so nothing on
  // the fetch port can reach an output combinationally.
  assign in_decode_exec  = (state == ST_DECODE) || (state == ST_EXEC);
  assign imem.imem_req   = (state == ST_FETCH);
  assign imem.imem_addr  = pc;
  assign halted          = (state == ST_HALT);
  assign reg_we          = (state == ST_EXEC) && (is_alu_op(instr.op) || (instr.op == OP_LDI));
  assign alu_src_imm     = in_decode_exec && (instr.op == OP_ADDI);
  assign wb_sel_imm      = in_decode_exec && (instr.op == OP_LDI);

endmodule
